// File: rtl/axi4l_pkg.sv
// AXI4-Lite shared types and the response error decode.
package axi4l_pkg;
   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;
   typedef logic [3:0]  strb_t;

   // SLVERR and DECERR both have the msb set; OKAY and EXOKAY do not.
   function automatic logic is_err(resp_t r);
      return r[1];
   endfunction
endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bus bundle; clock and reset travel with the bus.
interface axi4l_if (input logic aclk, input logic aresetn);
   import axi4l_pkg::*;
   logic  awvalid;
   logic  awready;
   addr_t awaddr;
   logic  wvalid;
   logic  wready;
   data_t wdata;
   strb_t wstrb;
   logic  bvalid;
   logic  bready;
   resp_t bresp;
   logic  arvalid;
   logic  arready;
   addr_t araddr;
   logic  rvalid;
   logic  rready;
   data_t rdata;
   resp_t rresp;

   modport master (input aclk, aresetn,
                   output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
                   input awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);
endinterface

// File: rtl/core_if.sv
// Core memory interface as seen by Ibex instruction/data ports.
interface core_if;
   import axi4l_pkg::*;
   logic  req;
   logic  gnt;
   logic  we;
   strb_t be;
   addr_t addr;
   data_t wdata;
   logic  rvalid;
   data_t rdata;
   logic  err;

   modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
   modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
endinterface

// File: rtl/core2axi4l.sv
// Core memory interface to AXI4-Lite master, one transaction outstanding.
// Response reaches core.rvalid in the R/B handshake cycle (REG_RESP=0) or one cycle later (REG_RESP=1).
module core2axi4l
   import axi4l_pkg::*;
#(
   parameter int unsigned REG_RESP = 0
) (
   core_if.slave   core,
   axi4l_if.master axi
);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD_ADDR  = 3'd1;
   localparam logic [2:0] RD_RESP  = 3'd2;
   localparam logic [2:0] WR_REQ   = 3'd3;
   localparam logic [2:0] WR_RESP  = 3'd4;
   localparam logic [2:0] RESP_OUT = 3'd5;

   logic [2:0] state;
   addr_t      addr_q;
   data_t      wdata_q;
   strb_t      be_q;
   logic       aw_done;
   logic       w_done;
   data_t      rdata_q;
   logic       err_q;

   logic       awvalid_int;
   logic       wvalid_int;
   logic       aw_hs;
   logic       w_hs;
   logic       r_hs;
   logic       b_hs;

   // Valids decode from registered state only, never from the matching ready.
   assign awvalid_int = (state == WR_REQ) & ~aw_done;
   assign wvalid_int  = (state == WR_REQ) & ~w_done;
   assign aw_hs       = awvalid_int & axi.awready;
   assign w_hs        = wvalid_int & axi.wready;
   assign r_hs        = (state == RD_RESP) & axi.rvalid;
   assign b_hs        = (state == WR_RESP) & axi.bvalid;

   assign core.gnt    = (state == IDLE) & core.req;

   assign axi.arvalid = (state == RD_ADDR);
   assign axi.araddr  = addr_q;
   assign axi.rready  = (state == RD_RESP);
   assign axi.awvalid = awvalid_int;
   assign axi.awaddr  = addr_q;
   assign axi.wvalid  = wvalid_int;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = be_q;
   assign axi.bready  = (state == WR_RESP);

   always_comb begin
      core.rvalid = 1'b0;
      core.rdata  = '0;
      core.err    = 1'b0;
      if (REG_RESP != 0) begin
         if (state == RESP_OUT) begin
            core.rvalid = 1'b1;
            core.rdata  = rdata_q;
            core.err    = err_q;
         end
      end else if (r_hs) begin
         core.rvalid = 1'b1;
         core.rdata  = axi.rdata;
         core.err    = is_err(axi.rresp);
      end else if (b_hs) begin
         core.rvalid = 1'b1;
         core.err    = is_err(axi.bresp);
      end
   end

   always_ff @(posedge axi.aclk or negedge axi.aresetn) begin
      if (!axi.aresetn) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (core.req) begin
                  addr_q  <= core.addr;
                  wdata_q <= core.wdata;
                  be_q    <= core.be;
                  state   <= core.we ? WR_REQ : RD_ADDR;
               end
            end
            RD_ADDR: begin
               if (axi.arready) state <= RD_RESP;
            end
            RD_RESP: begin
               if (axi.rvalid) begin
                  rdata_q <= axi.rdata;
                  err_q   <= is_err(axi.rresp);
                  state   <= (REG_RESP != 0) ? RESP_OUT : IDLE;
               end
            end
            WR_REQ: begin
               // AW and W may complete in either order or together.
               if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  state   <= WR_RESP;
               end else begin
                  aw_done <= aw_done | aw_hs;
                  w_done  <= w_done | w_hs;
               end
            end
            WR_RESP: begin
               if (axi.bvalid) begin
                  rdata_q <= '0;
                  err_q   <= is_err(axi.bresp);
                  state   <= (REG_RESP != 0) ? RESP_OUT : IDLE;
               end
            end
            RESP_OUT: state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_core2axi4l.sv
// Directed cycle-by-cycle vectors for core2axi4l; u1 (REG_RESP=1) mirrors u0's inputs.
module tb_core2axi4l;
   import axi4l_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   core_if  c0 ();
   core_if  c1 ();
   axi4l_if a0 (.aclk(clk), .aresetn(rst_n));
   axi4l_if a1 (.aclk(clk), .aresetn(rst_n));

   core2axi4l #(.REG_RESP(0)) u0 (.core(c0), .axi(a0));
   core2axi4l #(.REG_RESP(1)) u1 (.core(c1), .axi(a1));

   assign c1.req     = c0.req;
   assign c1.we      = c0.we;
   assign c1.be      = c0.be;
   assign c1.addr    = c0.addr;
   assign c1.wdata   = c0.wdata;
   assign a1.awready = a0.awready;
   assign a1.wready  = a0.wready;
   assign a1.bvalid  = a0.bvalid;
   assign a1.bresp   = a0.bresp;
   assign a1.arready = a0.arready;
   assign a1.rvalid  = a0.rvalid;
   assign a1.rdata   = a0.rdata;
   assign a1.rresp   = a0.rresp;

   typedef struct {
      logic        req, we;
      logic [3:0]  be;
      logic [31:0] addr, wdata;
      logic        arr, rv;
      logic [31:0] rd;
      resp_t       rr;
      logic        awr, wr, bv;
      resp_t       br;
      logic [7:0]  ef;   // {gnt, rvalid, err, arvalid, rready, awvalid, wvalid, bready}
      logic [31:0] erd;
      logic [1:0]  u1;   // {check u1, expected u1 rvalid}
   } vec_t;

   vec_t vq[$];
   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] cur_addr, cur_wd, last_rd;
   logic [3:0]  cur_be;
   logic        last_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] flags0();
      return {c0.gnt, c0.rvalid, c0.err, a0.arvalid, a0.rready, a0.awvalid, a0.wvalid, a0.bready};
   endfunction

   task automatic add(input logic req, we, input logic [3:0] be, input logic [31:0] addr, wdata,
                      input logic arr, rv, input logic [31:0] rd, input resp_t rr,
                      input logic awr, wr, bv, input resp_t br,
                      input logic [7:0] ef, input logic [31:0] erd, input logic [1:0] u1);
      vec_t v;
      v.req = req; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
      v.arr = arr; v.rv = rv; v.rd = rd; v.rr = rr;
      v.awr = awr; v.wr = wr; v.bv = bv; v.br = br;
      v.ef = ef; v.erd = erd; v.u1 = u1;
      vq.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      c0.req = v.req; c0.we = v.we; c0.be = v.be; c0.addr = v.addr; c0.wdata = v.wdata;
      a0.arready = v.arr; a0.rvalid = v.rv; a0.rdata = v.rd; a0.rresp = v.rr;
      a0.awready = v.awr; a0.wready = v.wr; a0.bvalid = v.bv; a0.bresp = v.br;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t z;
      z = '{req:0, we:0, be:0, addr:0, wdata:0, arr:0, rv:0, rd:0, rr:OKAY,
            awr:0, wr:0, bv:0, br:OKAY, ef:0, erd:0, u1:0};
      drive(z);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_flags_u0", flags0(), 8'h00);
      chk("reset_rdata_u0", c0.rdata, 32'h0);
      chk("reset_flags_u1", {c1.gnt, c1.rvalid, c1.err, a1.arvalid, a1.rready, a1.awvalid, a1.wvalid, a1.bready}, 8'h00);
      step();
      rst_n = 1'b1;

      // 1/6: read, arready two cycles after arvalid; u1 responds one cycle later
      add(1,0,4'h0,32'h1000_0004,0, 0,0,0,OKAY, 0,0,0,OKAY, 8'b1000_0000,0,2'b10);
      add(0,0,4'h0,0,0,             0,0,0,OKAY, 0,0,0,OKAY, 8'b0001_0000,0,2'b10);
      add(0,0,4'h0,0,0,             0,0,0,OKAY, 0,0,0,OKAY, 8'b0001_0000,0,2'b10);
      add(0,0,4'h0,0,0,             1,0,0,OKAY, 0,0,0,OKAY, 8'b0001_0000,0,2'b10);
      add(0,0,4'h0,0,0,             0,0,0,OKAY, 0,0,0,OKAY, 8'b0000_1000,0,2'b10);
      add(0,0,4'h0,0,0,             0,1,32'hDEAD_BEEF,OKAY, 0,0,0,OKAY, 8'b0100_1000,32'hDEAD_BEEF,2'b10);
      add(0,0,4'h0,0,0,             0,0,0,OKAY, 0,0,0,OKAY, 8'b0000_0000,0,2'b11);
      add(0,0,4'h0,0,0,             0,0,0,OKAY, 0,0,0,OKAY, 8'b0000_0000,0,2'b10);
      // 2: write, wready three cycles before awready
      add(1,1,4'b0011,32'h2000_0010,32'h1234_5678, 0,0,0,OKAY, 0,0,0,OKAY, 8'b1000_0000,0,2'b00);
      add(0,0,4'h0,0,0, 0,0,0,OKAY, 0,1,0,OKAY, 8'b0000_0110,0,2'b00);
      add(0,0,4'h0,0,0, 0,0,0,OKAY, 0,0,0,OKAY, 8'b0000_0100,0,2'b00);
      add(0,0,4'h0,0,0, 0,0,0,OKAY, 0,0,0,OKAY, 8'b0000_0100,0,2'b00);
      add(0,0,4'h0,0,0, 0,0,0,OKAY, 1,0,0,OKAY, 8'b0000_0100,0,2'b00);
      add(0,0,4'h0,0,0, 0,0,0,OKAY, 0,0,0,OKAY, 8'b0000_0001,0,2'b00);
      add(0,0,4'h0,0,0, 0,0,0,OKAY, 0,0,1,OKAY, 8'b0100_0001,0,2'b00);
      add(0,0,4'h0,0,0, 0,0,0,OKAY, 0,0,0,OKAY, 8'b0000_0000,0,2'b00);
      // 3: SLVERR read (arready high early), DECERR write
      add(1,0,4'h0,32'h3000_0000,0, 1,0,0,OKAY, 0,0,0,OKAY, 8'b1000_0000,0,2'b00);
      add(0,0,4'h0,0,0, 1,0,0,OKAY, 0,0,0,OKAY, 8'b0001_0000,0,2'b00);
      add(0,0,4'h0,0,0, 0,1,32'hBAD0_BAD0,SLVERR, 0,0,0,OKAY, 8'b0110_1000,32'hBAD0_BAD0,2'b00);
      add(0,0,4'h0,0,0, 0,0,0,OKAY, 0,0,0,OKAY, 8'b0000_0000,0,2'b00);
      add(1,1,4'hF,32'h4000_0008,32'hA5A5_A5A5, 0,0,0,OKAY, 0,0,0,OKAY, 8'b1000_0000,0,2'b00);
      add(0,0,4'h0,0,0, 0,0,0,OKAY, 1,1,0,OKAY, 8'b0000_0110,0,2'b00);
      add(0,0,4'h0,0,0, 0,0,0,OKAY, 0,0,1,DECERR, 8'b0110_0001,0,2'b00);
      add(0,0,4'h0,0,0, 0,0,0,OKAY, 0,0,0,OKAY, 8'b0000_0000,0,2'b00);
      // 4: req held across two reads, then a write with ready alongside valid
      add(1,0,4'h0,32'h5000_0000,0, 0,0,0,OKAY, 0,0,0,OKAY, 8'b1000_0000,0,2'b00);
      add(1,0,4'h0,32'h5000_0004,0, 1,0,0,OKAY, 0,0,0,OKAY, 8'b0001_0000,0,2'b00);
      add(1,0,4'h0,32'h5000_0004,0, 0,1,32'h1111_1111,OKAY, 0,0,0,OKAY, 8'b0100_1000,32'h1111_1111,2'b00);
      add(1,0,4'h0,32'h5000_0004,0, 0,0,0,OKAY, 0,0,0,OKAY, 8'b1000_0000,0,2'b00);
      add(1,1,4'b1100,32'h6000_0000,32'h0BAD_F00D, 1,0,0,OKAY, 0,0,0,OKAY, 8'b0001_0000,0,2'b00);
      add(1,1,4'b1100,32'h6000_0000,32'h0BAD_F00D, 0,1,32'h2222_2222,OKAY, 0,0,0,OKAY, 8'b0100_1000,32'h2222_2222,2'b00);
      add(1,1,4'b1100,32'h6000_0000,32'h0BAD_F00D, 0,0,0,OKAY, 0,0,0,OKAY, 8'b1000_0000,0,2'b00);
      add(0,0,4'h0,0,0, 0,0,0,OKAY, 1,1,0,OKAY, 8'b0000_0110,0,2'b00);
      add(0,0,4'h0,0,0, 0,0,0,OKAY, 0,0,1,OKAY, 8'b0100_0001,0,2'b00);
      add(0,0,4'h0,0,0, 0,0,0,OKAY, 0,0,0,OKAY, 8'b0000_0000,0,2'b00);

      foreach (vq[i]) begin
         drive(vq[i]);
         @(negedge clk);
         chk($sformatf("v%0d_flags", i), flags0(), vq[i].ef);
         if (vq[i].ef[7]) begin
            cur_addr = vq[i].addr; cur_wd = vq[i].wdata; cur_be = vq[i].be;
         end
         if (vq[i].ef[4]) chk($sformatf("v%0d_araddr", i), a0.araddr, cur_addr);
         if (vq[i].ef[2]) chk($sformatf("v%0d_awaddr", i), a0.awaddr, cur_addr);
         if (vq[i].ef[1]) begin
            chk($sformatf("v%0d_wdata", i), a0.wdata, cur_wd);
            chk($sformatf("v%0d_wstrb", i), {28'h0, a0.wstrb}, {28'h0, cur_be});
         end
         if (vq[i].ef[6]) begin
            chk($sformatf("v%0d_rdata", i), c0.rdata, vq[i].erd);
            last_rd = vq[i].erd; last_err = vq[i].ef[5];
         end
         if (vq[i].u1[1]) begin
            chk($sformatf("v%0d_u1_rvalid", i), {31'h0, c1.rvalid}, {31'h0, vq[i].u1[0]});
            if (vq[i].u1[0]) begin
               chk($sformatf("v%0d_u1_rdata", i), c1.rdata, last_rd);
               chk($sformatf("v%0d_u1_err", i), {31'h0, c1.err}, {31'h0, last_err});
            end
         end
         step();
      end

      // 5: reset while arvalid is pending
      drive(z);
      c0.req = 1'b1; c0.addr = 32'h7000_0000;
      @(negedge clk);
      chk("rst_gnt", flags0(), 8'b1000_0000);
      step();
      c0.req = 1'b0;
      @(negedge clk);
      chk("rst_arvalid_before", flags0(), 8'b0001_0000);
      #1;
      rst_n = 1'b0;
      a0.rvalid = 1'b1;
      #1;
      chk("rst_async_flags", flags0(), 8'h00);
      step();
      chk("rst_hold_flags", flags0(), 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_flags", flags0(), 8'h00);
      step();
      a0.rvalid = 1'b0;
      c0.req = 1'b1; c0.addr = 32'h7000_0010;
      @(negedge clk);
      chk("rst_regnt", flags0(), 8'b1000_0000);
      step();
      c0.req = 1'b0; a0.arready = 1'b1;
      @(negedge clk);
      chk("rst_rd_ar", flags0(), 8'b0001_0000);
      chk("rst_rd_araddr", a0.araddr, 32'h7000_0010);
      step();
      a0.arready = 1'b0; a0.rvalid = 1'b1; a0.rdata = 32'hCAFE_F00D; a0.rresp = EXOKAY;
      @(negedge clk);
      chk("rst_rd_resp", flags0(), 8'b0100_1000);
      chk("rst_rd_rdata", c0.rdata, 32'hCAFE_F00D);
      step();
      a0.rvalid = 1'b0;
      @(negedge clk);
      chk("rst_rd_idle", flags0(), 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/core2axi4l.md
Name: core2axi4l

Overview:
Converts the core memory interface (core_if, as used by the Ibex instruction and data ports) into an AXI4-Lite master. It is the initiator-side counterpart of the AXI4-Lite-to-core slave bridge. Typical placement is between an Ibex port and the AXI4-Lite interconnect. It supports one outstanding transaction at a time, and every request, read or write, returns exactly one single-cycle core.rvalid.

Parameters:
REG_RESP, 0, 0 = the AXI R/B response passes combinationally to core.rvalid/rdata/err; 1 = the response is registered, adding one cycle of latency.

Ports:
axi.aclk     input   1   clock (carried in axi4l_if)
axi.aresetn  input   1   asynchronous active-low reset (carried in axi4l_if)
core.req     input   1   request from core
core.gnt     output  1   request accepted
core.we      input   1   1 = write
core.be      input   4   byte enables
core.addr    input   32  byte address
core.wdata   input   32  write data
core.rvalid  output  1   response strobe, one cycle
core.rdata   output  32  read data
core.err     output  1   response error
axi.aw*      output  awvalid, awaddr[31:0]; input awready
axi.w*       output  wvalid, wdata[31:0], wstrb[3:0]; input wready
axi.b*       input   bvalid, bresp[1:0]; output bready
axi.ar*      output  arvalid, araddr[31:0]; input arready
axi.r*       input   rvalid, rdata[31:0], rresp[1:0]; output rready
Module header: core_if.slave core, axi4l_if.master axi.

Behaviour:
- States: IDLE, RD_ADDR, RD_RESP, WR_REQ, WR_RESP, plus RESP_OUT when REG_RESP=1.
- Reset: state = IDLE. All valids (arvalid, awvalid, wvalid), core.gnt and core.rvalid are 0. core.rdata and err are 0. bready and rready are 0.
- IDLE:
  - core.gnt = core.req, combinationally, in the same cycle.
  - On req: capture addr, wdata, be and we into registers.
  - Next state: RD_ADDR if we=0, WR_REQ if we=1.
  - gnt is never asserted outside IDLE.
- RD_ADDR:
  - arvalid=1 and araddr come from the captured registers and stay stable until arready.
  - On arready, go to RD_RESP.
- RD_RESP:
  - rready=1.
  - On axi.rvalid with REG_RESP=0: core.rvalid=1, core.rdata=axi.rdata, core.err=rresp[1], same cycle; go to IDLE.
- WR_REQ:
  - awvalid and wvalid are asserted together on entry.
  - aw_done and w_done flags latch their own handshakes independently. Each valid drops the cycle after its own handshake.
  - When both are done (including both in the same cycle), go to WR_RESP and clear the flags.
- WR_RESP:
  - bready=1.
  - On bvalid: core.rvalid=1, core.err=bresp[1], core.rdata=0; go to IDLE.
- REG_RESP=1:
  - The response is captured into rdata_q/err_q, and the FSM goes to RESP_OUT.
  - RESP_OUT drives core.rvalid=1 from the registers for one cycle, then goes to IDLE.
  - rready/bready still accept in the response cycle.
- Error mapping: SLVERR and DECERR give err=1; OKAY and EXOKAY give err=0.
- Request throughput: a new request is granted no earlier than the cycle after core.rvalid. A request held high during a transaction waits.
- AXI compliance:
  - No valid depends combinationally on the matching ready.
  - Address and data stay stable while valid is high and not yet accepted.
  - A ready arriving before valid is tolerated.
- Reset mid-transaction: the FSM returns to IDLE asynchronously. All valids and rvalid drop, and the outstanding transaction is discarded with no core response.
- core.rdata and err are don't-care when rvalid=0, but are driven 0 in IDLE.

Decomposition:
- axi4l_pkg holds:
  - resp_t (OKAY, EXOKAY, SLVERR, DECERR), addr_t, data_t, strb_t.
  - A new function is_err(resp_t) that returns logic.
- The state enum is local to the module.
- No sub-module is needed. The single FSM plus capture registers fit in roughly 200 lines.

Test Plan:
1. Read, REG_RESP=0:
   - Stimulus: req, we=0, addr=0x1000_0004; arready 2 cycles after arvalid; rvalid with rdata=0xDEADBEEF, OKAY.
   - Response: gnt in cycle 0; araddr=0x1000_0004 from cycle 1; core.rvalid pulses for exactly 1 cycle with rdata=0xDEADBEEF, err=0.
2. Write, wready 3 cycles before awready:
   - Stimulus: addr=0x2000_0010, wdata=0x1234_5678, be=4'b0011.
   - Response: wvalid drops after wready; awvalid is held until awready; wstrb=0011. bvalid OKAY produces one rvalid with err=0.
3. Error responses:
   - Stimulus: read returning rresp=SLVERR; write returning bresp=DECERR.
   - Response: each gives core.err=1 with rvalid 1 cycle.
4. Back-to-back:
   - Stimulus: req held high for two reads; awready and wready asserted in the same cycle as the valids for an interleaved write.
   - Response: the second gnt comes exactly 1 cycle after the first rvalid; no extra valid cycles occur.
5. Reset mid-transaction:
   - Stimulus: aresetn low while arvalid=1 and arready=0.
   - Response: arvalid=0 immediately; no core.rvalid ever; after release, the next req is granted in IDLE.
6. REG_RESP=1:
   - Stimulus: same as scenario 1.
   - Response: core.rvalid appears 1 cycle after the axi.rvalid handshake, with identical rdata and err.
